function_generator_loader: RTL

// - Upstream stage of function_generator: parses a byte-wide command stream into RAM writes and read-length updates.
// - Two packet types:
//   - WRITE packet: emits one write_enable pulse per data byte.
//   - SET_END packet: updates end_read_address.
// - Sits between the host byte link (uart/spi receiver) and function_generator's write port.

---
 rtl/function_generator_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/function_generator_loader.sv
// function_generator_loader: turns a byte-wide command stream into RAM write
// strobes (WRITE packet, sync 0xA5) and end_read_address updates (SET_END
// packet, sync 0x5A) for function_generator.
// Optional feature: define FUNCTION_GENERATOR_LOADER_CHECKSUM_EN to require a
// trailing checksum byte on every packet.
module function_generator_loader #(
  parameter int DATA_BUS_WIDTH    = 8,
  parameter int ADDRESS_BUS_DEPTH = 11,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ADDRESS_BUS_DEPTH-1:0] write_address,
  output logic [DATA_BUS_WIDTH-1:0]    data_out,
  output logic                         write_enable,
  output logic [ADDRESS_BUS_DEPTH-1:0] end_read_address,
  output logic                         busy,
  output logic                         packet_done,
  output logic                         error,
  output logic [7:0]                   error_count
);

  localparam int AW = ADDRESS_BUS_DEPTH;
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN_HI,
    LEN_LO,
    DATA,
    END_HI,
    END_LO,
`ifdef FUNCTION_GENERATOR_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          w_accept;
  logic          w_bad_sync;
  logic          w_chk_fail;
  logic          w_timeout;
  logic          w_err_event;

  logic [7:0]    r_addr_hi;
  logic [AW-1:0] r_ptr;
  logic [15:0]   r_len;
  logic [7:0]    r_end_hi;
  logic [AW-1:0] r_end_pend;
  logic          r_is_setend;
  logic [GW-1:0] r_gap;
  logic          r_we;
  logic [AW-1:0] r_wa;
  logic [DATA_BUS_WIDTH-1:0] r_dout;
  logic [AW-1:0] r_end;
  logic          r_error;
  logic [7:0]    r_err_cnt;
`ifdef FUNCTION_GENERATOR_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = DONE;
`endif

  // in_ready follows the reset input directly so no byte is taken while reset is high
  assign in_ready         = !reset && (r_state != DONE);
  assign w_accept         = in_valid && in_ready;
  assign busy             = (r_state != IDLE);
  assign packet_done      = (r_state == DONE);
  assign write_enable     = r_we;
  assign write_address    = r_wa;
  assign data_out         = r_dout;
  assign end_read_address = r_end;
  assign error            = r_error;
  assign error_count      = r_err_cnt;
  assign w_err_event      = w_bad_sync || w_chk_fail || w_timeout;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and error event detection
  always_comb begin
    w_next     = r_state;
    w_bad_sync = 1'b0;
    w_chk_fail = 1'b0;
    w_timeout  = busy && !w_accept && (r_gap == GW'(TIMEOUT_CYCLES - 1));
    if (r_state == DONE) begin
      w_next = IDLE;
    end else if (w_timeout) begin
      w_next = IDLE;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (in_data == 8'hA5)      w_next = ADDR_HI;
          else if (in_data == 8'h5A) w_next = END_HI;
          else                       w_bad_sync = 1'b1;
        end
        ADDR_HI: w_next = ADDR_LO;
        ADDR_LO: w_next = LEN_HI;
        LEN_HI:  w_next = LEN_LO;
        LEN_LO:  w_next = ({r_len[15:8], in_data} == 16'd0) ? TAIL : DATA;
        DATA:    if (r_len == 16'd1) w_next = TAIL;
        END_HI:  w_next = END_LO;
        END_LO:  w_next = TAIL;
`ifdef FUNCTION_GENERATOR_LOADER_CHECKSUM_EN
        CHECK: begin
          if (8'(r_sum + in_data) == 8'h00) begin
            w_next = DONE;
          end else begin
            w_next     = IDLE;
            w_chk_fail = 1'b1;
          end
        end
`endif
        default: w_next = IDLE;
      endcase
    end
  end

  // Field capture, write strobes, gap timer, end address and error bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr_hi   <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_end_hi    <= '0;
      r_end_pend  <= '0;
      r_is_setend <= 1'b0;
      r_gap       <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_dout      <= '0;
      r_end       <= '0;
      r_error     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_we    <= 1'b0;
      r_error <= w_err_event;
      if (w_err_event && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_accept || !busy || w_timeout) r_gap <= '0;
      else                                r_gap <= r_gap + 1'b1;

      if (w_accept) begin
        case (r_state)
          IDLE:    r_is_setend <= (in_data == 8'h5A);
          ADDR_HI: r_addr_hi   <= in_data;
          ADDR_LO: r_ptr       <= AW'({r_addr_hi, in_data});
          LEN_HI:  r_len[15:8] <= in_data;
          LEN_LO:  r_len[7:0]  <= in_data;
          DATA: begin
            r_we   <= 1'b1;
            r_wa   <= r_ptr;
            r_dout <= DATA_BUS_WIDTH'(in_data);
            r_ptr  <= r_ptr + 1'b1;
            r_len  <= r_len - 16'd1;
          end
          END_HI:  r_end_hi   <= in_data;
          END_LO:  r_end_pend <= AW'({r_end_hi, in_data});
          default: ;
        endcase
      end

      if ((r_state == DONE) && r_is_setend) r_end <= r_end_pend;
    end
  end

`ifdef FUNCTION_GENERATOR_LOADER_CHECKSUM_EN
  // Running 8-bit sum of every byte after the sync byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_accept) begin
      if (r_state == IDLE) r_sum <= '0;
      else                 r_sum <= r_sum + in_data;
    end
  end
`endif

endmodule
